pwm_oc_break_ctrl: RTL and testbench
====================================

# pwm_oc_break_ctrl

Output-control and break stage of the PWM channel, placed directly downstream of the deadtime stage. Takes the deadtime-separated high/low pair, applies output polarity, and gates both outputs through a main-output-enable (MOE) state machine. A synchronised, digitally filtered external break input forces both pins to programmed idle levels. MOE is restored either by software or automatically on an update event.

## Interface
Parameters:
- FILTER_W, 4, width of the break filter length and the filter counter.

Ports:
- clk_psc_i  in  1  prescaled clock; all logic on its rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- update_event_i  in  1  single-cycle update-event pulse.
- pwm_high_i  in  1  main phase from the deadtime stage.
- pwm_low_i  in  1  complementary phase from the deadtime stage.
- break_i  in  1  external break pin; asynchronous to clk_psc_i.
- bke_i  in  1  break enable.
- bkp_i  in  1  break polarity; 1 = active-high, 0 = active-low.
- bkf_i  in  FILTER_W  break filter length N, in cycles.
- aoe_i  in  1  automatic output enable: restore MOE on update event.
- moe_set_i  in  1  software MOE set pulse.
- moe_clr_i  in  1  software MOE clear pulse.
- ccp_i / ccnp_i  in  1 each  polarity inversion for the main / complementary output.
- ois_i / oisn_i  in  1 each  idle level for the main / complementary output.
- bif_clr_i  in  1  break flag clear pulse.
- pwm_p_o / pwm_n_o  out  1 each  pin-level outputs. Registered; reset value 0.
- moe_o  out  1  1 when in state RUN. Reset value 0.
- break_active_o  out  1  1 when in state BREAK. Reset value 0.
- break_flag_o  out  1  sticky break-event flag. Reset value 0.

## Operation
- **Synchroniser.** break_i passes through a 2-flop synchroniser to produce brk_sync.
  - brk_lvl = bkp_i ? brk_sync : ~brk_sync.
- **Filter.** Counter cnt, FILTER_W bits.
  - When brk_lvl=0, cnt is cleared to 0.
  - When brk_lvl=1, cnt increments and saturates at bkf_i.
  - brk_det = bke_i & brk_lvl & (cnt == bkf_i).
  - With bkf_i=0, brk_det follows brk_lvl directly.
  - A pulse shorter than N+1 synchronised cycles is rejected.
- **FSM.** States IDLE, RUN, BREAK. Reset state is IDLE. Priority: break > clear > set.
  - IDLE: brk_det → BREAK; else moe_set_i → RUN.
  - RUN: brk_det → BREAK; else moe_clr_i → IDLE.
  - BREAK, while brk_det=1: stay. moe_set_i and update_event_i are ignored.
  - BREAK, once brk_det=0:
    - moe_set_i → RUN.
    - else aoe_i & update_event_i → RUN.
    - else ~aoe_i → IDLE.
    - else (aoe_i=1, no update event) stay in BREAK.
  - Clearing bke_i while in BREAK makes brk_det=0; the release rules above then apply.
- **Outputs.** Registered from the next state.
  - Next state RUN: pwm_p_o ← pwm_high_i ^ ccp_i; pwm_n_o ← pwm_low_i ^ ccnp_i.
  - Otherwise: pwm_p_o ← ois_i; pwm_n_o ← oisn_i.
  - moe_o and break_active_o are decoded from the state register.
- **Flag.** break_flag_o is set on any cycle with brk_det=1 and cleared by bif_clr_i. Set wins when set and clear coincide.
- **Config.** The configuration inputs are static and are not shadowed.

## Timing
- Data path: pwm_high_i/pwm_low_i to pwm_p_o/pwm_n_o has 1 cycle latency in RUN.
- Break assertion: edge k is the first edge at which synchroniser flop 1 captures active break_i.
  - Outputs reach idle levels, and break_active_o and break_flag_o assert, at edge k+2+N.
- Break release, brk_sync inactive from edge m:
  - brk_det drops combinationally after edge m.
  - With aoe_i=0: IDLE at edge m+1.
  - With aoe_i=1: RUN at the first edge, ≥ m+1, with update_event_i=1.
- Simultaneous brk_det and moe_set_i: result is BREAK.
- Simultaneous moe_set_i and moe_clr_i in RUN: result is IDLE.
- Reset mid-operation: every flop clears immediately (asynchronously).
  - Outputs go to 0, not ois_i; idle levels apply from the first clock after release.
  - The filter counter and synchroniser are cleared.
- Filter counter never wraps.
  - If bkf_i is lowered below cnt, brk_det asserts when cnt reaches bkf_i again; since cnt ≥ bkf_i already, that is the next edge, through the saturation compare.

## Test plan
- Reset, then moe_set_i pulse, ccp_i=1, pwm_high_i=1, pwm_low_i=0 → moe_o=1; one cycle later pwm_p_o=0, pwm_n_o=0.
- bke_i=1, bkp_i=1, bkf_i=0, ois_i=1, oisn_i=0, break_i high at edge k → at edge k+2 pwm_p_o=1, pwm_n_o=0, break_active_o=1, break_flag_o=1.
- bkf_i=3, break_i high for 3 synchronised cycles then low → no break and flag stays 0. Break_i high for 4 cycles → break at k+5.
- aoe_i=1, break released → stays in BREAK until the next update_event_i pulse, then moe_o=1 at that edge. Repeat with aoe_i=0 → IDLE one cycle after release, and moe_o stays 0 until moe_set_i.
- break_i held active with moe_set_i pulsed → remains in BREAK. bif_clr_i and brk_det in the same cycle → flag stays 1.
- rst_n_i asserted while in RUN with outputs toggling → all outputs 0 asynchronously. After release, state is IDLE and outputs follow ois_i/oisn_i.

Source files
------------

// File: rtl/pwm_oc_break_ctrl.sv
// PWM output-control and break stage: applies pin polarity, gates the deadtime pair
// through a main-output-enable FSM, and forces idle levels on a filtered break input.
module pwm_oc_break_ctrl #(
  parameter int FILTER_W = 4
) (
  input  logic                clk_psc_i,
  input  logic                rst_n_i,
  input  logic                update_event_i,
  input  logic                pwm_high_i,
  input  logic                pwm_low_i,
  input  logic                break_i,
  input  logic                bke_i,
  input  logic                bkp_i,
  input  logic [FILTER_W-1:0] bkf_i,
  input  logic                aoe_i,
  input  logic                moe_set_i,
  input  logic                moe_clr_i,
  input  logic                ccp_i,
  input  logic                ccnp_i,
  input  logic                ois_i,
  input  logic                oisn_i,
  input  logic                bif_clr_i,
  output logic                pwm_p_o,
  output logic                pwm_n_o,
  output logic                moe_o,
  output logic                break_active_o,
  output logic                break_flag_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BREAK = 2'd2
  } state_t;

  logic                r_sync1;
  logic                r_sync2;
  logic                w_brk_lvl;
  logic [FILTER_W-1:0] r_cnt;
  logic                w_brk_det;
  state_t              r_state;
  state_t              w_next;
  logic                r_pwm_p;
  logic                r_pwm_n;
  logic                r_flag;

  // break_i is asynchronous to clk_psc_i; two flops before any logic sees it.
  // NOTE: non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= break_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_brk_lvl = bkp_i ? r_sync2 : ~r_sync2;

  // Saturating filter; clamping to bkf_i (rather than holding) lets a lowered
  // filter length take effect on the very next edge without ever wrapping.
  always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (!w_brk_lvl) begin
      r_cnt <= '0;
    end else if (r_cnt < bkf_i) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= bkf_i;
    end
  end

  assign w_brk_det = bke_i & w_brk_lvl & (r_cnt == bkf_i);

  // Priority everywhere is break > clear > set.
  always_comb begin
    // NOTE: default first so every path assigns w_next and no latch is inferred.
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_brk_det)      w_next = ST_BREAK;
        else if (moe_set_i) w_next = ST_RUN;
      end
      ST_RUN: begin
        if (w_brk_det)      w_next = ST_BREAK;
        else if (moe_clr_i) w_next = ST_IDLE;
      end
      ST_BREAK: begin
        if (!w_brk_det) begin
          if (moe_set_i)                   w_next = ST_RUN;
          else if (aoe_i && update_event_i) w_next = ST_RUN;
          else if (!aoe_i)                 w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Pins are registered from the next state so they change on the same edge as the FSM.
  always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_pwm_p <= 1'b0;
      r_pwm_n <= 1'b0;
      r_flag  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == ST_RUN) begin
        r_pwm_p <= pwm_high_i ^ ccp_i;
        r_pwm_n <= pwm_low_i ^ ccnp_i;
      end else begin
        r_pwm_p <= ois_i;
        r_pwm_n <= oisn_i;
      end
      if (w_brk_det)      r_flag <= 1'b1;
      else if (bif_clr_i) r_flag <= 1'b0;
    end
  end

  assign pwm_p_o        = r_pwm_p;
  assign pwm_n_o        = r_pwm_n;
  assign moe_o          = (r_state == ST_RUN);
  assign break_active_o = (r_state == ST_BREAK);
  assign break_flag_o   = r_flag;

endmodule

// File: tb/tb_pwm_oc_break_ctrl.sv
// Directed bench for pwm_oc_break_ctrl: a vector table for MOE/polarity behaviour
// plus hand-written sequences for break filtering, release and reset.
module tb_pwm_oc_break_ctrl;

  localparam int FILTER_W = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                update_event = 1'b0;
  logic                pwm_high = 1'b0;
  logic                pwm_low = 1'b0;
  logic                break_in = 1'b0;
  logic                bke = 1'b0;
  logic                bkp = 1'b1;
  logic [FILTER_W-1:0] bkf = '0;
  logic                aoe = 1'b0;
  logic                moe_set = 1'b0;
  logic                moe_clr = 1'b0;
  logic                ccp = 1'b0;
  logic                ccnp = 1'b0;
  logic                ois = 1'b0;
  logic                oisn = 1'b0;
  logic                bif_clr = 1'b0;
  logic                pwm_p;
  logic                pwm_n;
  logic                moe;
  logic                break_active;
  logic                break_flag;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pwm_oc_break_ctrl #(.FILTER_W(FILTER_W)) dut (
    .clk_psc_i      (clk),
    .rst_n_i        (rst_n),
    .update_event_i (update_event),
    .pwm_high_i     (pwm_high),
    .pwm_low_i      (pwm_low),
    .break_i        (break_in),
    .bke_i          (bke),
    .bkp_i          (bkp),
    .bkf_i          (bkf),
    .aoe_i          (aoe),
    .moe_set_i      (moe_set),
    .moe_clr_i      (moe_clr),
    .ccp_i          (ccp),
    .ccnp_i         (ccnp),
    .ois_i          (ois),
    .oisn_i         (oisn),
    .bif_clr_i      (bif_clr),
    .pwm_p_o        (pwm_p),
    .pwm_n_o        (pwm_n),
    .moe_o          (moe),
    .break_active_o (break_active),
    .break_flag_o   (break_flag)
  );

  typedef struct packed {
    logic set, clr, upd, aoe, high, low, ccp, ccnp, ois, oisn;
    logic exp_p, exp_n, exp_moe;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_set();
    moe_set = 1'b1;
    tick(1);
    moe_set = 1'b0;
  endtask

  initial begin
    //            set clr upd aoe high low ccp ccnp ois oisn | p n moe
    vecs[0] = 13'b0___0___0___0___0____0___0___0____1___0____1_0_0;
    vecs[1] = 13'b1___0___0___0___1____0___1___0____1___0____0_0_1;
    vecs[2] = 13'b0___0___0___0___0____1___1___0____1___0____1_1_1;
    vecs[3] = 13'b0___0___0___0___1____0___0___1____1___0____1_1_1;
    vecs[4] = 13'b0___0___0___0___0____1___0___1____1___0____0_0_1;
    vecs[5] = 13'b1___1___0___0___0____0___0___0____0___1____0_1_0;
    vecs[6] = 13'b0___0___1___1___0____0___0___0____1___1____1_1_0;
    vecs[7] = 13'b1___0___0___0___1____1___0___0____1___1____1_1_1;
    vecs[8] = 13'b0___1___0___0___0____0___0___0____0___0____0_0_0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_p", pwm_p, 1'b0);
    check("rst_n", pwm_n, 1'b0);
    check("rst_moe", moe, 1'b0);
    check("rst_brk", break_active, 1'b0);
    check("rst_flag", break_flag, 1'b0);
    rst_n = 1'b1;

    // MOE set/clear, polarity and idle levels (break disabled)
    for (int i = 0; i < 9; i++) begin
      moe_set = vecs[i].set;  moe_clr = vecs[i].clr;  update_event = vecs[i].upd;
      aoe = vecs[i].aoe;      pwm_high = vecs[i].high; pwm_low = vecs[i].low;
      ccp = vecs[i].ccp;      ccnp = vecs[i].ccnp;     ois = vecs[i].ois;
      oisn = vecs[i].oisn;
      tick(1);
      check($sformatf("vec%0d_p", i), pwm_p, vecs[i].exp_p);
      check($sformatf("vec%0d_n", i), pwm_n, vecs[i].exp_n);
      check($sformatf("vec%0d_moe", i), moe, vecs[i].exp_moe);
      check($sformatf("vec%0d_brk", i), break_active, 1'b0);
    end
    moe_set = 1'b0; moe_clr = 1'b0; update_event = 1'b0;

    // Unfiltered break (N=0) from RUN, with aoe=1 release on update event
    ois = 1'b1; oisn = 1'b0; ccp = 1'b0; ccnp = 1'b0;
    pwm_high = 1'b1; pwm_low = 1'b0; aoe = 1'b1;
    bke = 1'b1; bkp = 1'b1; bkf = 4'd0;
    pulse_set();
    check("b0_moe", moe, 1'b1);
    check("b0_p", pwm_p, 1'b1);
    break_in = 1'b1;
    tick(2);
    check("b0_k1_brk", break_active, 1'b0);
    check("b0_k1_moe", moe, 1'b1);
    tick(1);
    check("b0_k2_brk", break_active, 1'b1);
    check("b0_k2_p", pwm_p, 1'b1);
    check("b0_k2_n", pwm_n, 1'b0);
    check("b0_k2_flag", break_flag, 1'b1);
    check("b0_k2_moe", moe, 1'b0);
    moe_set = 1'b1; bif_clr = 1'b1;
    tick(1);
    moe_set = 1'b0; bif_clr = 1'b0;
    check("b0_set_ign_brk", break_active, 1'b1);
    check("b0_flag_set_wins", break_flag, 1'b1);
    break_in = 1'b0;
    tick(2);
    check("b0_m_brk", break_active, 1'b1);
    bif_clr = 1'b1;
    tick(1);
    bif_clr = 1'b0;
    check("b0_aoe_hold", break_active, 1'b1);
    check("b0_flag_clr", break_flag, 1'b0);
    tick(2);
    check("b0_aoe_hold2", break_active, 1'b1);
    check("b0_aoe_hold2_moe", moe, 1'b0);
    update_event = 1'b1; pwm_high = 1'b0;
    tick(1);
    update_event = 1'b0;
    check("b0_upd_moe", moe, 1'b1);
    check("b0_upd_brk", break_active, 1'b0);
    check("b0_upd_p", pwm_p, 1'b0);

    // Break then release with aoe=0: IDLE one edge after release
    pwm_high = 1'b1;
    break_in = 1'b1;
    tick(3);
    check("b1_brk", break_active, 1'b1);
    aoe = 1'b0; break_in = 1'b0;
    tick(2);
    check("b1_m_brk", break_active, 1'b1);
    tick(1);
    check("b1_idle_brk", break_active, 1'b0);
    check("b1_idle_moe", moe, 1'b0);
    check("b1_idle_p", pwm_p, 1'b1);
    check("b1_idle_n", pwm_n, 1'b0);
    tick(3);
    check("b1_stay_moe", moe, 1'b0);
    pulse_set();
    check("b1_set_moe", moe, 1'b1);

    // Filter N=3: 3-cycle pulse rejected, 4-cycle pulse breaks at k+5
    bkf = 4'd3;
    bif_clr = 1'b1;
    tick(1);
    bif_clr = 1'b0;
    break_in = 1'b1;
    tick(3);
    break_in = 1'b0;
    tick(6);
    check("f3_short_brk", break_active, 1'b0);
    check("f3_short_flag", break_flag, 1'b0);
    check("f3_short_moe", moe, 1'b1);
    break_in = 1'b1;
    tick(4);
    break_in = 1'b0;
    tick(1);
    check("f3_k4_brk", break_active, 1'b0);
    tick(1);
    check("f3_k5_brk", break_active, 1'b1);
    check("f3_k5_flag", break_flag, 1'b1);
    tick(1);
    check("f3_rel_brk", break_active, 1'b0);
    check("f3_rel_moe", moe, 1'b0);

    // Lowering bkf below the running count: break through the saturation compare
    tick(3);
    pulse_set();
    bkf = 4'd15;
    break_in = 1'b1;
    tick(8);
    check("sat_pre_brk", break_active, 1'b0);
    bkf = 4'd2;
    tick(1);
    check("sat_j1_brk", break_active, 1'b0);
    tick(1);
    check("sat_j2_brk", break_active, 1'b1);
    bke = 1'b0;
    tick(1);
    check("bke_off_brk", break_active, 1'b0);
    check("bke_off_moe", moe, 1'b0);
    break_in = 1'b0; bke = 1'b1;
    tick(3);

    // Asynchronous reset while RUN with toggling outputs
    ois = 1'b1; oisn = 1'b1;
    pulse_set();
    for (int i = 0; i < 4; i++) begin
      pwm_high = i[0];
      tick(1);
      check($sformatf("rr_tog%0d_p", i), pwm_p, i[0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_p", pwm_p, 1'b0);
    check("ar_n", pwm_n, 1'b0);
    check("ar_moe", moe, 1'b0);
    check("ar_brk", break_active, 1'b0);
    check("ar_flag", break_flag, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    check("ar_rel_p", pwm_p, 1'b1);
    check("ar_rel_n", pwm_n, 1'b1);
    check("ar_rel_moe", moe, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
